// File: rtl/mc6809_clk_pkg.sv
// Shared definitions for the 6809 clock/reset generator: sequencer states and
// the quarter-phase to {E,Q} mapping.
package mc6809_clk_pkg;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_FILT = 2'd1,
      ST_HOLD = 2'd2,
      ST_RUN  = 2'd3
   } state_t;

   // {E,Q} per quarter-phase; Q leads E by one quarter
   localparam logic [1:0] EQ_PH0 = 2'b00;
   localparam logic [1:0] EQ_PH1 = 2'b01;
   localparam logic [1:0] EQ_PH2 = 2'b11;
   localparam logic [1:0] EQ_PH3 = 2'b10;

   function automatic logic [1:0] phase_to_eq(input logic [1:0] phase);
      logic [1:0] eq;
      case (phase)
         2'd0:    eq = EQ_PH0;
         2'd1:    eq = EQ_PH1;
         2'd2:    eq = EQ_PH2;
         default: eq = EQ_PH3;
      endcase
      return eq;
   endfunction

endpackage

// File: rtl/mc6809_clk_rst_gen_lock_sync.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module lock_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mc6809_clk_rst_gen.sv
// 6809 E/Q quadrature clock-enable generator and CPU reset sequencer.
//   state | meaning
//   WAIT  | no lock seen; CPU held in reset
//   FILT  | lock present, counting LOCK_FILTER stable cycles
//   HOLD  | filter passed, counting RST_E_CYCLES E falling edges
//   RUN   | CPU released, READY high
module mc6809_clk_rst_gen #(
   parameter int DIV          = 4,
   parameter int LOCK_FILTER  = 1024,
   parameter int RST_E_CYCLES = 16
) (
   input  logic CLK,
   input  logic RESET_n,
   input  logic LOCKED,
   output logic E,
   output logic Q,
   output logic E_RISE,
   output logic E_FALL,
   output logic Q_RISE,
   output logic Q_FALL,
   output logic CPU_RESET_n,
   output logic READY
);

   import mc6809_clk_pkg::*;

   localparam int QW = $clog2(DIV + 1);
   localparam int FW = $clog2(LOCK_FILTER + 1);
   localparam int EW = $clog2(RST_E_CYCLES + 1);

   localparam logic [QW-1:0] Q_LAST = QW'(DIV - 1);
   localparam logic [FW-1:0] F_LAST = FW'(LOCK_FILTER - 1);
   localparam logic [FW-1:0] F_MAX  = FW'(LOCK_FILTER);
   localparam logic [EW-1:0] E_LAST = EW'(RST_E_CYCLES - 1);

   logic [QW-1:0] qcnt;
   logic [1:0]    phase;
   logic [1:0]    phase_nxt;
   logic [1:0]    eq_nxt;
   logic          qwrap;
   logic          lock_s;

   state_t        state;
   logic [FW-1:0] fcnt;
   logic [EW-1:0] ecnt;

   assign qwrap     = (qcnt == Q_LAST);
   assign phase_nxt = qwrap ? phase + 2'd1 : phase;
   assign eq_nxt    = phase_to_eq(phase_nxt);

   // Free-running phase generator; only RESET_n ever disturbs it
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         qcnt   <= '0;
         phase  <= 2'd0;
         E      <= 1'b0;
         Q      <= 1'b0;
         E_RISE <= 1'b0;
         E_FALL <= 1'b0;
         Q_RISE <= 1'b0;
         Q_FALL <= 1'b0;
      end else begin
         qcnt   <= qwrap ? '0 : qcnt + QW'(1);
         phase  <= phase_nxt;
         E      <= eq_nxt[1];
         Q      <= eq_nxt[0];
         E_RISE <=  eq_nxt[1] & ~E;
         E_FALL <= ~eq_nxt[1] &  E;
         Q_RISE <=  eq_nxt[0] & ~Q;
         Q_FALL <= ~eq_nxt[0] &  Q;
      end
   end

   lock_sync u_lock_sync (
      .clk   (CLK),
      .rst_n (RESET_n),
      .d     (LOCKED),
      .q     (lock_s)
   );

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state       <= ST_WAIT;
         fcnt        <= '0;
         ecnt        <= '0;
         CPU_RESET_n <= 1'b0;
         READY       <= 1'b0;
      end else if (!lock_s) begin
         state       <= ST_WAIT;
         CPU_RESET_n <= 1'b0;
         READY       <= 1'b0;
      end else begin
         case (state)
            ST_WAIT: begin
               state       <= ST_FILT;
               fcnt        <= '0;
               CPU_RESET_n <= 1'b0;
               READY       <= 1'b0;
            end
            ST_FILT: begin
               CPU_RESET_n <= 1'b0;
               READY       <= 1'b0;
               if (fcnt == F_LAST) begin
                  state <= ST_HOLD;
                  ecnt  <= '0;
               end else if (fcnt != F_MAX) begin
                  fcnt <= fcnt + FW'(1);
               end
            end
            ST_HOLD: begin
               // E_FALL is the registered strobe, so release lands one CLK after it
               if (E_FALL) begin
                  if (ecnt == E_LAST) begin
                     state       <= ST_RUN;
                     CPU_RESET_n <= 1'b1;
                     READY       <= 1'b1;
                  end else begin
                     ecnt <= ecnt + EW'(1);
                  end
               end
            end
            ST_RUN: begin
               CPU_RESET_n <= 1'b1;
               READY       <= 1'b1;
            end
            default: begin
               state       <= ST_WAIT;
               CPU_RESET_n <= 1'b0;
               READY       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mc6809_clk_rst_gen.sv
// Scoreboard bench: expected output events are queued per cycle, monitors pop
// and compare whenever a strobe fires or E/Q or {CPU_RESET_n,READY} change.
module tb_mc6809_clk_rst_gen;

   typedef struct {
      int         cyc;
      logic [3:0] str;   // {Q_RISE, E_RISE, Q_FALL, E_FALL}
      logic [1:0] eq;    // {E, Q}
      logic [1:0] rr;    // {CPU_RESET_n, READY}
   } ev_t;

   logic CLK, RESET_n, LOCKED, LOCKED1;

   logic a_e, a_q, a_er, a_ef, a_qr, a_qf, a_cr, a_rd;
   logic b_e, b_q, b_er, b_ef, b_qr, b_qf, b_cr, b_rd;

   int   k;
   int   tests;
   int   fails;
   ev_t  exp4[$];
   ev_t  exp1[$];
   logic [1:0] prev_eq[2];
   logic [1:0] prev_rr[2];

   int         chg_k[6];
   logic [1:0] chg_v[6];
   int         n_chg;

   mc6809_clk_rst_gen #(.DIV(4), .LOCK_FILTER(8), .RST_E_CYCLES(2)) dut (
      .CLK(CLK), .RESET_n(RESET_n), .LOCKED(LOCKED),
      .E(a_e), .Q(a_q), .E_RISE(a_er), .E_FALL(a_ef), .Q_RISE(a_qr), .Q_FALL(a_qf),
      .CPU_RESET_n(a_cr), .READY(a_rd)
   );

   mc6809_clk_rst_gen #(.DIV(1), .LOCK_FILTER(8), .RST_E_CYCLES(2)) dut1 (
      .CLK(CLK), .RESET_n(RESET_n), .LOCKED(LOCKED1),
      .E(b_e), .Q(b_q), .E_RISE(b_er), .E_FALL(b_ef), .Q_RISE(b_qr), .Q_FALL(b_qf),
      .CPU_RESET_n(b_cr), .READY(b_rd)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Edges since the most recent reset release
   always @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) k <= 0;
      else          k <= k + 1;
   end

   // Expected event stream for cycles 1..kmax: phase after edge kk is (kk/div)%4
   task automatic plan(input int sel, input int div, input int kmax, input bit use_chg);
      ev_t        ev;
      int         ph, ci;
      logic [1:0] eq, eq_prev, rr;
      logic [3:0] s;
      bit         rr_chg;
      eq_prev = 2'b00;
      rr      = 2'b00;
      ci      = 0;
      for (int kk = 1; kk <= kmax; kk++) begin
         ph     = (kk / div) % 4;
         s      = 4'b0000;
         rr_chg = 1'b0;
         if (kk % div == 0) begin
            case (ph)
               1:       s = 4'b1000;
               2:       s = 4'b0100;
               3:       s = 4'b0010;
               default: s = 4'b0001;
            endcase
         end
         case (ph)
            0:       eq = 2'b00;
            1:       eq = 2'b01;
            2:       eq = 2'b11;
            default: eq = 2'b10;
         endcase
         if (use_chg && ci < n_chg && chg_k[ci] == kk) begin
            rr     = chg_v[ci];
            ci     = ci + 1;
            rr_chg = 1'b1;
         end
         if (s != 4'b0000 || eq != eq_prev || rr_chg) begin
            ev.cyc = kk;
            ev.str = s;
            ev.eq  = eq;
            ev.rr  = rr;
            if (sel == 0) exp4.push_back(ev);
            else          exp1.push_back(ev);
         end
         eq_prev = eq;
      end
   endtask

   task automatic observe(input int sel, input logic [3:0] s, input logic [1:0] eq,
                          input logic [1:0] rr);
      logic [1:0] pe, pr;
      ev_t        ex;
      bit         have;
      string      nm;
      nm = (sel == 0) ? "dut_div4" : "dut_div1";
      pe = (k == 1) ? 2'b00 : prev_eq[sel];
      pr = (k == 1) ? 2'b00 : prev_rr[sel];
      if (s != 4'b0000 || eq != pe || rr != pr) begin
         tests = tests + 1;
         have  = (sel == 0) ? (exp4.size() != 0) : (exp1.size() != 0);
         if (!have) begin
            fails = fails + 1;
            $display("FAIL %s_unexpected k=%0d: got str=%b eq=%b rr=%b, required no event",
                     nm, k, s, eq, rr);
         end else begin
            if (sel == 0) ex = exp4.pop_front();
            else          ex = exp1.pop_front();
            if (ex.cyc != k || ex.str != s || ex.eq != eq || ex.rr != rr) begin
               fails = fails + 1;
               $display("FAIL %s_event: got k=%0d str=%b eq=%b rr=%b, required k=%0d str=%b eq=%b rr=%b",
                        nm, k, s, eq, rr, ex.cyc, ex.str, ex.eq, ex.rr);
            end
         end
      end
      prev_eq[sel] = eq;
      prev_rr[sel] = rr;
   endtask

   always @(negedge CLK) begin
      if (RESET_n && k >= 1) begin
         observe(0, {a_qr, a_er, a_qf, a_ef}, {a_e, a_q}, {a_cr, a_rd});
         observe(1, {b_qr, b_er, b_qf, b_ef}, {b_e, b_q}, {b_cr, b_rd});
      end
   end

   task automatic check_zero(input string nm);
      tests = tests + 1;
      if ({a_e, a_q, a_er, a_ef, a_qr, a_qf, a_cr, a_rd} != 8'h00) begin
         fails = fails + 1;
         $display("FAIL %s_div4: got outputs %b, required 00000000", nm,
                  {a_e, a_q, a_er, a_ef, a_qr, a_qf, a_cr, a_rd});
      end
      tests = tests + 1;
      if ({b_e, b_q, b_er, b_ef, b_qr, b_qf, b_cr, b_rd} != 8'h00) begin
         fails = fails + 1;
         $display("FAIL %s_div1: got outputs %b, required 00000000", nm,
                  {b_e, b_q, b_er, b_ef, b_qr, b_qf, b_cr, b_rd});
      end
   endtask

   task automatic check_drained(input string nm);
      tests = tests + 1;
      if (exp4.size() != 0) begin
         fails = fails + 1;
         $display("FAIL %s_div4: %0d expected events not seen (first k=%0d), required 0",
                  nm, exp4.size(), exp4[0].cyc);
      end
      tests = tests + 1;
      if (exp1.size() != 0) begin
         fails = fails + 1;
         $display("FAIL %s_div1: %0d expected events not seen (first k=%0d), required 0",
                  nm, exp1.size(), exp1[0].cyc);
      end
   endtask

   task automatic wait_k(input int t);
      while (k < t) @(negedge CLK);
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      RESET_n = 1'b0;
      LOCKED  = 1'b0;
      LOCKED1 = 1'b0;
      #3;
      check_zero("reset_initial");
      #19;
      RESET_n = 1'b1;

      // LOCKED set after edge r: FILT from r+3, HOLD from r+11, release one CLK
      // after the second E_FALL (k%16==0) at or past r+11. Drop after d -> low at d+3.
      chg_k[0] = 81;  chg_v[0] = 2'b11;  // lock r=40: HOLD 51, E_FALL 64,80
      chg_k[1] = 103; chg_v[1] = 2'b00;  // drop in RUN at 100
      chg_k[2] = 161; chg_v[2] = 2'b11;  // relock r=120: HOLD 131, E_FALL 144,160
      chg_k[3] = 173; chg_v[3] = 2'b00;  // drop at 170
      chg_k[4] = 241; chg_v[4] = 2'b11;  // lock 196, glitch 202..205: HOLD 216, E_FALL 224,240
      chg_k[5] = 263; chg_v[5] = 2'b00;  // drop at 260
      n_chg    = 6;
      plan(0, 4, 283, 1'b1);
      plan(1, 1, 283, 1'b0);

      wait_k(40);  LOCKED = 1'b1;
      wait_k(100); LOCKED = 1'b0;
      wait_k(120); LOCKED = 1'b1;
      wait_k(170); LOCKED = 1'b0;
      wait_k(196); LOCKED = 1'b1;
      wait_k(202); LOCKED = 1'b0;
      wait_k(205); LOCKED = 1'b1;
      wait_k(260); LOCKED = 1'b0;
      wait_k(283);

      // Asynchronous reset pulse between clock edges while E=Q=1
      #2;
      check_drained("segment1_drain");
      RESET_n = 1'b0;
      #1;
      check_zero("reset_midphase");
      #1;
      RESET_n = 1'b1;

      n_chg = 0;
      plan(0, 4, 40, 1'b0);
      plan(1, 1, 40, 1'b0);
      wait_k(40);
      #2;
      check_drained("segment2_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
